// File: rtl/pe_acc_sched_if.sv
// pe_acc_sched_if: handshake/config bundle between the PE scheduler and the fetch/PE side.
interface pe_acc_sched_if #(parameter int CH_W = 8, parameter int PIX_W = 16);
  logic             start;
  logic [CH_W-1:0]  num_ch;
  logic [PIX_W-1:0] num_pix;
  logic             cfg_relu;
  logic             cfg_quan;
  logic             if_req;
  logic [CH_W-1:0]  if_ch;
  logic [PIX_W-1:0] if_pix;
  logic             if_valid;
  logic             psum_sel;
  logic             relu_en;
  logic             quan_en;
  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic             busy;
  logic             done;
  logic [31:0]      perf_stall_cnt;
  modport master (
    input  start, num_ch, num_pix, cfg_relu, cfg_quan, if_valid,
    output if_req, if_ch, if_pix, psum_sel, relu_en, quan_en, out_valid, out_pix, busy, done,
           perf_stall_cnt
  );
  modport slave (
    output start, num_ch, num_pix, cfg_relu, cfg_quan, if_valid,
    input  if_req, if_ch, if_pix, psum_sel, relu_en, quan_en, out_valid, out_pix, busy, done,
           perf_stall_cnt
  );
endinterface

// File: rtl/pe_acc_sched.sv
// pe_acc_sched: sequences C channels x P pixels through a PE_LAT-deep 5x5 PE, steering psum/relu/quan.
// Optional stall counter enabled by defining PE_ACC_SCHED_PERF_EN.
module pe_acc_sched #(
  parameter int PE_LAT = 3,
  parameter int CH_W   = 8,
  parameter int PIX_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  pe_acc_sched_if.master bus
);
  localparam int GAP = PE_LAT - 2;
  typedef enum logic [2:0] {IDLE, ISSUE, GAP_S, DRAIN, DONE} state_t;
  state_t                       r_state, w_state_nx;
  logic [7:0]                   r_gap, w_gap_nx;
  logic [CH_W-1:0]              r_num_ch, r_ch;
  logic [PIX_W-1:0]             r_num_pix, r_pix;
  logic                         r_relu, r_quan, r_psum;
  logic [PE_LAT-1:0]            r_pv, r_pl;
  logic [PE_LAT-1:0][PIX_W-1:0] r_pp;
  logic                         w_start, w_issue, w_ch_last, w_pix_last, w_out;
  assign w_start    = r_state == IDLE && bus.start;
  assign w_issue    = r_state == ISSUE && bus.if_valid;
  assign w_ch_last  = r_ch == r_num_ch - CH_W'(1);
  assign w_pix_last = r_pix == r_num_pix - PIX_W'(1);
  assign w_out      = r_pv[PE_LAT-1] & r_pl[PE_LAT-1];
  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = r_gap;
    case (r_state)
      IDLE:  if (bus.start) w_state_nx = (bus.num_ch == '0 || bus.num_pix == '0) ? DRAIN : ISSUE;
      ISSUE: if (w_issue) begin
        w_gap_nx   = '0;
        w_state_nx = (w_ch_last && w_pix_last) ? DRAIN : (GAP == 0 ? ISSUE : GAP_S);
      end
      GAP_S: begin
        w_gap_nx   = r_gap + 8'd1;
        w_state_nx = r_gap == 8'(GAP - 1) ? ISSUE : GAP_S;
      end
      // the final sum is in the last pipe stage once nothing earlier remains in flight
      DRAIN:   w_state_nx = |r_pv[PE_LAT-2:0] ? DRAIN : DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gap     <= '0;
      r_num_ch  <= '0;
      r_num_pix <= '0;
      r_relu    <= 1'b0;
      r_quan    <= 1'b0;
      r_ch      <= '0;
      r_pix     <= '0;
      r_psum    <= 1'b0;
      r_pv      <= '0;
      r_pl      <= '0;
      r_pp      <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gap   <= w_gap_nx;
      if (w_start) begin
        r_num_ch  <= bus.num_ch;
        r_num_pix <= bus.num_pix;
        r_relu    <= bus.cfg_relu;
        r_quan    <= bus.cfg_quan;
        r_ch      <= '0;
        r_pix     <= '0;
      end else if (w_issue) begin
        r_ch <= w_ch_last ? '0 : r_ch + CH_W'(1);
        if (w_ch_last) r_pix <= w_pix_last ? '0 : r_pix + PIX_W'(1);
      end
      r_psum <= w_issue && r_ch != '0;
      r_pv   <= {r_pv[PE_LAT-2:0], w_issue};
      r_pl   <= {r_pl[PE_LAT-2:0], w_issue && w_ch_last};
      r_pp   <= {r_pp[PE_LAT-2:0], r_pix};
    end
  end
  assign bus.if_req    = r_state == ISSUE;
  assign bus.if_ch     = r_ch;
  assign bus.if_pix    = r_pix;
  assign bus.psum_sel  = r_psum;
  assign bus.out_valid = w_out;
  assign bus.out_pix   = w_out ? r_pp[PE_LAT-1] : '0;
  assign bus.relu_en   = w_out & r_relu;
  assign bus.quan_en   = w_out & r_quan;
  assign bus.busy      = r_state != IDLE;
  assign bus.done      = r_state == DONE;
`ifdef PE_ACC_SCHED_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else if (w_start) r_stall <= '0;
    else if (r_state == ISSUE && !bus.if_valid && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
  assign bus.perf_stall_cnt = r_stall;
`else
  assign bus.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pe_acc_sched.sv
// tb_pe_acc_sched: random and directed layer passes; a negedge monitor scores the DUT against
// expectations pushed from a loop-level model of the channel/pixel schedule.
module tb_pe_acc_sched;
  localparam int PE_LAT = 3, CH_W = 8, PIX_W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  pe_acc_sched_if #(.CH_W(CH_W), .PIX_W(PIX_W)) bus ();
  pe_acc_sched #(.PE_LAT(PE_LAT), .CH_W(CH_W), .PIX_W(PIX_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int ch; int pix;} iss_t;
  typedef struct {int pix; bit relu; bit quan;} out_t;
  iss_t exp_iss[$];
  out_t exp_out[$];
  int   out_due[$], iss_log[$], out_log[$];
  int   cyc = 0, n_chk = 0, n_pass = 0, stalls = 0, cur_c = 0, done_log = -1;
  int   psum_cyc = -1, psum_val = 0, gap_lo = -1, gap_hi = -1, req_cyc = -1, done_cyc = -1;
  int   busy_from = 32'h7fffffff;
  bit   mon_en = 1'b0, done_seen = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(string nm);
    chk({nm, "_if_req"}, bus.if_req, 0);
    chk({nm, "_if_ch"}, bus.if_ch, 0);
    chk({nm, "_if_pix"}, bus.if_pix, 0);
    chk({nm, "_psum"}, bus.psum_sel, 0);
    chk({nm, "_relu"}, bus.relu_en, 0);
    chk({nm, "_quan"}, bus.quan_en, 0);
    chk({nm, "_ovalid"}, bus.out_valid, 0);
    chk({nm, "_opix"}, bus.out_pix, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_perf"}, bus.perf_stall_cnt, 0);
  endtask
  task automatic cmp_log(string nm, input int q[$], input int s, input int e[$]);
    chk({nm, "_count"}, q.size(), e.size());
    for (int i = 0; i < q.size() && i < e.size(); i++) chk(nm, q[i] - s, e[i]);
  endtask
  // monitor / scoreboard
  always @(negedge clk) begin
    iss_t e;
    out_t o;
    int   t;
    if (mon_en) begin
      chk("psum_sel", bus.psum_sel, cyc == psum_cyc ? psum_val : 0);
      if (bus.if_req && !bus.if_valid) stalls++;
      if (cyc >= gap_lo && cyc <= gap_hi) chk("req_in_gap", bus.if_req, 0);
      if (cyc == req_cyc) chk("req_after_gap", bus.if_req, 1);
      if (bus.if_req && bus.if_valid) begin
        iss_log.push_back(cyc);
        chk("iss_expected", exp_iss.size() > 0, 1);
        if (exp_iss.size() > 0) begin
          e = exp_iss.pop_front();
          chk("iss_ch", bus.if_ch, e.ch);
          chk("iss_pix", bus.if_pix, e.pix);
          psum_cyc = cyc + 1;
          psum_val = e.ch != 0;
          if (e.ch == cur_c - 1) out_due.push_back(cyc + PE_LAT);
          gap_lo = cyc + 1;
          gap_hi = exp_iss.size() > 0 ? cyc + PE_LAT - 2 : 32'h7fffffff;
          req_cyc = exp_iss.size() > 0 ? cyc + PE_LAT - 1 : -1;
        end
      end
      if (bus.out_valid) begin
        out_log.push_back(cyc);
        chk("out_time", cyc, out_due.size() > 0 ? out_due[0] : -1);
        if (out_due.size() > 0) t = out_due.pop_front();
        chk("out_expected", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) begin
          o = exp_out.pop_front();
          chk("out_pix", bus.out_pix, o.pix);
          chk("relu_en", bus.relu_en, o.relu);
          chk("quan_en", bus.quan_en, o.quan);
          if (exp_out.size() == 0) done_cyc = cyc + 1;
        end
      end else begin
        chk("relu_idle", bus.relu_en, 0);
        chk("quan_idle", bus.quan_en, 0);
        if (out_due.size() > 0 && out_due[0] <= cyc) begin
          chk("out_missing", bus.out_valid, 1);
          t = out_due.pop_front();
        end
      end
      if (cyc >= busy_from && !done_seen) chk("busy", bus.busy, 1);
      chk("done", bus.done, cyc == done_cyc);
      if (bus.done) begin
        done_seen = 1'b1;
        done_log  = cyc;
      end
    end
  end
  task automatic run_pass(int c, int p, bit relu, bit quan, int stall0, int pct, output int s);
    int n;
    exp_iss.delete(); exp_out.delete(); out_due.delete(); iss_log.delete(); out_log.delete();
    for (int pi = 0; pi < p; pi++) begin
      for (int ci = 0; ci < c; ci++) exp_iss.push_back('{ci, pi});
      if (c > 0) exp_out.push_back('{pi, relu, quan});
    end
    cur_c = c; psum_cyc = -1; gap_lo = -1; gap_hi = -1; req_cyc = -1;
    done_seen = 1'b0; done_log = -1; stalls = 0;
    s         = cyc;
    done_cyc  = (c == 0 || p == 0) ? s + 2 : -1;
    busy_from = s + 1;
    bus.start = 1'b1; bus.num_ch = CH_W'(c); bus.num_pix = PIX_W'(p);
    bus.cfg_relu = relu; bus.cfg_quan = quan;
    tick;
    n = 0;
    while (!done_seen && n < 4000) begin
      bus.start    = ($urandom % 4) == 0;
      bus.num_ch   = CH_W'($urandom);
      bus.num_pix  = PIX_W'($urandom);
      bus.cfg_relu = $urandom_range(0, 1);
      bus.cfg_quan = $urandom_range(0, 1);
      bus.if_valid = n < stall0 ? 1'b0 : $urandom_range(0, 99) >= pct;
      tick;
      n++;
    end
    bus.start = 1'b0;
    bus.if_valid = 1'b0;
    chk("done_seen", done_seen, 1);
    @(negedge clk);
    chk("idle_after_done", bus.busy, 0);
    chk("iss_left", exp_iss.size(), 0);
    chk("out_left", exp_out.size(), 0);
`ifdef PE_ACC_SCHED_PERF_EN
    chk("perf_stall_cnt", bus.perf_stall_cnt, stalls);
`else
    chk("perf_stall_cnt", bus.perf_stall_cnt, 0);
`endif
    tick;
  endtask
  initial begin
    int s;
    #200000;
    $display("FAIL watchdog @%0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int s;
    bus.start = 0; bus.num_ch = 0; bus.num_pix = 0; bus.cfg_relu = 0; bus.cfg_quan = 0; bus.if_valid = 0;
    tick; tick;
    chk_zero("reset");
    rst_n = 1'b1;
    tick;
    mon_en = 1'b1;
    run_pass(3, 2, 1, 1, 0, 0, s);
    cmp_log("d1_issue", iss_log, s, '{1, 3, 5, 7, 9, 11});
    cmp_log("d1_out", out_log, s, '{8, 14});
    chk("d1_done", done_log - s, 15);
    run_pass(1, 4, 0, 0, 0, 0, s);
    cmp_log("d2_issue", iss_log, s, '{1, 3, 5, 7});
    cmp_log("d2_out", out_log, s, '{4, 6, 8, 10});
    chk("d2_done", done_log - s, 11);
    run_pass(2, 1, 0, 1, 3, 0, s);
    cmp_log("d3_issue", iss_log, s, '{4, 6});
    cmp_log("d3_out", out_log, s, '{9});
`ifdef PE_ACC_SCHED_PERF_EN
    chk("d3_perf", bus.perf_stall_cnt, 3);
`else
    chk("d3_perf", bus.perf_stall_cnt, 0);
`endif
    run_pass(0, 5, 1, 1, 0, 0, s);
    chk("d4_done", done_log - s, 2);
    chk("d4_issue_count", iss_log.size(), 0);
    run_pass(4, 0, 0, 0, 0, 0, s);
    chk("d5_done", done_log - s, 2);
    for (int k = 0; k < 10; k++)
      run_pass($urandom_range(1, 5), $urandom_range(1, 6), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 50), s);
    mon_en = 1'b0;
    s = cyc;
    bus.start = 1'b1; bus.num_ch = 4; bus.num_pix = 8; bus.cfg_relu = 1; bus.cfg_quan = 1;
    tick;
    bus.start = 1'b0;
    bus.if_valid = 1'b1;
    while (cyc < s + 6) tick;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    chk("midreset_busy_hold", bus.busy, 0);
    tick;
    rst_n = 1'b1;
    bus.if_valid = 1'b0;
    tick;
    done_cyc = -1;
    mon_en = 1'b1;
    run_pass(4, 8, 1, 0, 0, 20, s);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
